// File: rtl/aes_pkg.sv
// Shared AES datapath types and GF(2^8) helpers for the round stages.
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  col_t;
  typedef logic [127:0] state_t;

  // Reduction term for x^8+x^4+x^3+x+1 once the x^8 bit is dropped
  localparam byte_t POLY = 8'h1B;

  // Multiply by x (0x02) in GF(2^8)
  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? POLY : 8'h00);
  endfunction

  // Column-major byte position inside the 128-bit state
  function automatic int unsigned idx(input int unsigned row, input int unsigned col);
    return row + 4 * col;
  endfunction

endpackage

// File: rtl/mix_column.sv
// Combinational MixColumns / InvMixColumns on one 32-bit column.
// Byte r of the column sits at bits [8r+7:8r].
module mix_column
  import aes_pkg::*;
(
  input  logic [31:0] i_col,
  input  logic        i_inverse,
  output logic [31:0] o_col
);

  byte_t w_a  [4];
  byte_t w_x2 [4];
  byte_t w_x4 [4];
  byte_t w_x8 [4];

  // Powers of x for every byte; all matrix coefficients are sums of these
  always_comb begin
    for (int unsigned r = 0; r < 4; r++) begin
      w_a[r]  = i_col[8*r +: 8];
      w_x2[r] = xtime(w_a[r]);
      w_x4[r] = xtime(w_x2[r]);
      w_x8[r] = xtime(w_x4[r]);
    end
  end

  // Row r uses the base matrix row rotated right by r
  always_comb begin
    o_col = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      int unsigned r1, r2, r3;
      r1 = (r + 1) % 4;
      r2 = (r + 2) % 4;
      r3 = (r + 3) % 4;
      if (i_inverse) begin
        // 0e*a0 ^ 0b*a1 ^ 0d*a2 ^ 09*a3
        o_col[8*r +: 8] = (w_x8[r] ^ w_x4[r] ^ w_x2[r])
                        ^ (w_x8[r1] ^ w_x2[r1] ^ w_a[r1])
                        ^ (w_x8[r2] ^ w_x4[r2] ^ w_a[r2])
                        ^ (w_x8[r3] ^ w_a[r3]);
      end else begin
        // 02*a0 ^ 03*a1 ^ a2 ^ a3
        o_col[8*r +: 8] = w_x2[r]
                        ^ (w_x2[r1] ^ w_a[r1])
                        ^ w_a[r2]
                        ^ w_a[r3];
      end
    end
  end

endmodule

// File: rtl/shift_mix_stage.sv
// Two-stage round datapath: (Inv)ShiftRows into stage 1, (Inv)MixColumns
// into stage 2, with valid/ready handshaking and per-beat mode flags.
module shift_mix_stage
  import aes_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [127:0]     stateIn,
  input  logic             validIn,
  output logic             readyOut,
  input  logic             inverse,
  input  logic             lastRound,
  input  logic [TAG_W-1:0] tagIn,
  output logic [127:0]     stateOut,
  output logic             validOut,
  input  logic             readyIn,
  output logic [TAG_W-1:0] tagOut
);

  state_t           r_s1_data;
  logic [TAG_W-1:0] r_s1_tag;
  logic             r_s1_inv;
  logic             r_s1_last;
  logic             r_s1_valid;

  state_t           r_s2_data;
  logic [TAG_W-1:0] r_s2_tag;
  logic             r_s2_valid;

  state_t w_shift_fwd;
  state_t w_shift_inv;
  state_t w_shifted;
  state_t w_mixed;
  state_t w_s2_next;
  logic   w_s2_load_ok;
  logic   w_s1_adv;
  logic   w_accept;

  // Row rotation is pure byte wiring; both directions built, one selected
  always_comb begin
    w_shift_fwd = '0;
    w_shift_inv = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        w_shift_fwd[8*idx(r, c) +: 8] = stateIn[8*idx(r, (c + r) % 4) +: 8];
        w_shift_inv[8*idx(r, c) +: 8] = stateIn[8*idx(r, (c + 4 - r) % 4) +: 8];
      end
    end
  end

  assign w_shifted = inverse ? w_shift_inv : w_shift_fwd;

  for (genvar c = 0; c < 4; c++) begin : g_mix
    mix_column u_mix (
      .i_col     (r_s1_data[32*c +: 32]),
      .i_inverse (r_s1_inv),
      .o_col     (w_mixed[32*c +: 32])
    );
  end

  assign w_s2_next = r_s1_last ? r_s1_data : w_mixed;

  // Ready is combinational from readyIn so a full pipe streams without bubbles
  assign w_s2_load_ok = !r_s2_valid || readyIn;
  assign w_s1_adv     = r_s1_valid && w_s2_load_ok;
  assign readyOut     = !rst && (!r_s1_valid || w_s1_adv);
  assign w_accept     = validIn && readyOut;

  // Stage 1: capture shifted state and the beat's own mode flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_tag   <= '0;
      r_s1_inv   <= 1'b0;
      r_s1_last  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_data  <= w_shifted;
        r_s1_tag   <= tagIn;
        r_s1_inv   <= inverse;
        r_s1_last  <= lastRound;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2: output register, holds while downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_tag   <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s2_valid <= 1'b1;
        r_s2_data  <= w_s2_next;
        r_s2_tag   <= r_s1_tag;
      end else if (readyIn) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  assign stateOut = r_s2_data;
  assign tagOut   = r_s2_tag;
  assign validOut = r_s2_valid;

endmodule

// File: tb/tb_shift_mix_stage.sv
// Scoreboard bench for shift_mix_stage using FIPS-197 round vectors.
module tb_shift_mix_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] stateIn;
  logic         validIn;
  logic         readyOut;
  logic         inverse;
  logic         lastRound;
  logic [3:0]   tagIn;
  logic [127:0] stateOut;
  logic         validOut;
  logic         readyIn;
  logic [3:0]   tagOut;

  shift_mix_stage #(.TAG_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .stateIn   (stateIn),
    .validIn   (validIn),
    .readyOut  (readyOut),
    .inverse   (inverse),
    .lastRound (lastRound),
    .tagIn     (tagIn),
    .stateOut  (stateOut),
    .validOut  (validOut),
    .readyIn   (readyIn),
    .tagOut    (tagOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    logic [3:0]   t;
  } exp_t;

  exp_t q[$];
  int   pop_cyc[$];
  int   cyc = 0;
  int   acc_cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [127:0] A, X, B, C;

  always @(posedge clk) cyc <= cyc + 1;

  // Vectors are written byte0 first; place byte0 at bits [7:0]
  function automatic logic [127:0] L(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = v[8*(15-i) +: 8];
    return r;
  endfunction

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every output transfer
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && validOut === 1'b1 && readyIn === 1'b1) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got tag %0d expected no beat", tagOut);
        end else begin
          e = q.pop_front();
          check("data", stateOut, e.d);
          check("tag", {124'd0, tagOut}, {124'd0, e.t});
          pop_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic send(input logic [127:0] d, input logic inv, input logic last,
                      input logic [3:0] tag, input logic [127:0] exp);
    exp_t e;
    int   n;
    n         = 0;
    validIn   = 1'b1;
    stateIn   = d;
    inverse   = inv;
    lastRound = last;
    tagIn     = tag;
    @(negedge clk);
    while (readyOut !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (readyOut !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got readyOut=%b expected 1 (tag %0d)", readyOut, tag);
    end else begin
      e.d = exp;
      e.t = tag;
      q.push_back(e);
      acc_cyc = cyc;
    end
    @(posedge clk);
    #1;
    validIn = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    logic seen;
    int   start;

    A = L(128'hd42711aee0bf98f1b8b45de51e415230);
    X = L(128'h046681e5e0cb199a48f8d37a2806264c);
    B = L(128'hd4bf5d30e0b452aeb84111f11e2798e5);
    C = L(128'h04cbd34ce0f826e54806819a2866197a);

    rst       = 1'b1;
    validIn   = 1'b0;
    stateIn   = '0;
    inverse   = 1'b0;
    lastRound = 1'b0;
    tagIn     = '0;
    readyIn   = 1'b1;
    #1;
    check("reset_validOut", {127'd0, validOut}, 128'd0);
    check("reset_stateOut", stateOut, 128'd0);
    check("reset_tagOut", {124'd0, tagOut}, 128'd0);
    check("reset_readyOut", {127'd0, readyOut}, 128'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_readyOut", {127'd0, readyOut}, 128'd1);
    @(posedge clk);
    #1;

    // 1: forward round, plus accept-to-output latency
    pop_cyc.delete();
    send(A, 1'b0, 1'b0, 4'h5, X);
    drain();
    if (pop_cyc.size() > 0) check("latency", 128'(pop_cyc[0] - acc_cyc), 128'd2);
    else check("latency_beats", 128'(pop_cyc.size()), 128'd1);

    // 2,3: forward last round, inverse round, inverse last round
    send(A, 1'b0, 1'b1, 4'h6, B);
    send(C, 1'b1, 1'b0, 4'h7, B);
    send(B, 1'b1, 1'b1, 4'h8, A);
    drain();

    // 4: backpressure fills both stages, then releases in order
    readyIn = 1'b0;
    send(A, 1'b0, 1'b0, 4'h1, X);
    send(A, 1'b0, 1'b1, 4'h2, B);
    validIn   = 1'b1;
    stateIn   = C;
    inverse   = 1'b1;
    lastRound = 1'b0;
    tagIn     = 4'h3;
    repeat (4) begin
      @(negedge clk);
      check("stall_readyOut", {127'd0, readyOut}, 128'd0);
      check("stall_validOut", {127'd0, validOut}, 128'd1);
      check("stall_stateOut", stateOut, X);
      check("stall_tagOut", {124'd0, tagOut}, 128'd1);
    end
    @(posedge clk);
    #1;
    readyIn = 1'b1;
    send(C, 1'b1, 1'b0, 4'h3, B);
    send(B, 1'b1, 1'b1, 4'h4, A);
    drain();

    // 5: mixed modes back-to-back at full rate
    pop_cyc.delete();
    start = cyc;
    for (int i = 0; i < 8; i++) begin
      case (i % 4)
        0: send(A, 1'b0, 1'b0, 4'(8 + i), X);
        1: send(C, 1'b1, 1'b0, 4'(8 + i), B);
        2: send(A, 1'b0, 1'b1, 4'(8 + i), B);
        default: send(B, 1'b1, 1'b1, 4'(8 + i), A);
      endcase
    end
    check("accept_rate", 128'(cyc - start), 128'd8);
    drain();
    check("output_beats", 128'(pop_cyc.size()), 128'd8);
    if (pop_cyc.size() == 8) check("output_rate", 128'(pop_cyc[7] - pop_cyc[0]), 128'd7);

    // 6: reset with two beats in flight discards them
    send(A, 1'b0, 1'b0, 4'hA, X);
    send(A, 1'b0, 1'b1, 4'hB, B);
    rst = 1'b1;
    #1;
    check("midreset_validOut", {127'd0, validOut}, 128'd0);
    check("midreset_stateOut", stateOut, 128'd0);
    check("midreset_tagOut", {124'd0, tagOut}, 128'd0);
    check("midreset_readyOut", {127'd0, readyOut}, 128'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("release_readyOut", {127'd0, readyOut}, 128'd1);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (validOut !== 1'b0) seen = 1'b1;
    end
    check("no_stale_beat", {127'd0, seen}, 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
